ds_engine: RTL and testbench
============================

Name: ds_engine

Overview:
2x2 box-filter down-sampler that answers the controller's ds_run/ds_done handshake.
- On run, reads the source image from the image ROM at 4 reads per output pixel.
- Averages each 2x2 block with rounding and writes one pixel per block into the half-resolution frame RAM.
- The up-sampler consumes that RAM afterwards.
- Completion is signalled by a four-phase level handshake.

Parameters:
PIX_W, 8, grayscale pixel width in bits
SRC_W, 64, source image width in pixels (even, >=2)
SRC_H, 64, source image height in pixels (even, >=2)
ROM_LAT, 1, ROM read latency in cycles (en to data), 1..4

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ds_run_i  input  1  run request from controller (level)
ds_done_o  output  1  done acknowledge (level)
busy_o  output  1  high while processing
rom_en_o  output  1  ROM read enable
rom_addr_o  output  $clog2(SRC_W*SRC_H)  ROM address = y*SRC_W + x
rom_data_i  input  PIX_W  ROM read data, valid ROM_LAT cycles after rom_en_o
ram_we_o  output  1  frame RAM write enable
ram_addr_o  output  $clog2(SRC_W*SRC_H/4)  RAM address = oy*(SRC_W/2) + ox
ram_wdata_o  output  PIX_W  averaged pixel

Behaviour:
- Clock, reset: one clock clk; rst_n asynchronous assert, active low.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-operation: immediately returns to IDLE with outputs 0. No partial write completes after reset.
- IDLE:
  - ds_run_i=1 sampled -> FETCH, busy_o=1 from the next cycle.
  - ox=oy=0, k=0, acc=0.
- FETCH: 4 cycles with k=0..3 and rom_en_o=1.
  - k=0: addr (2oy)*SRC_W+2ox
  - k=1: +1
  - k=2: +SRC_W
  - k=3: +SRC_W+1
  - Then -> WAIT.
- Data capture: a ROM_LAT-deep valid shift register follows rom_en_o. Each valid cycle does acc += rom_data_i.
  - acc is PIX_W+2 bits and cannot overflow: 4*255=1020.
- WAIT: ROM_LAT cycles, rom_en_o=0, until the 4th datum is accumulated -> WRITE.
- WRITE: one cycle.
  - ram_we_o=1, ram_addr_o=oy*(SRC_W/2)+ox, ram_wdata_o=(acc+2)>>2 (round half up).
  - acc cleared.
  - If last block (ox=SRC_W/2-1 and oy=SRC_H/2-1) -> DONE.
  - Else advance ox; on wrap ox=0 and oy++; -> FETCH.
- Cost: 4+ROM_LAT+1 cycles per output pixel. Defaults give 6 cycles, 1024 pixels, 6144 cycles from FETCH entry to DONE entry.
- DONE: ds_done_o=1, busy_o=0; stays while ds_run_i=1. ds_run_i=0 -> ds_done_o=0 next cycle, -> IDLE.
- ds_run_i deasserted mid-operation: ignored; the frame always completes. DONE then shows ds_done_o for exactly 1 cycle and returns to IDLE.
- ds_run_i held high after ack: no restart. A new frame needs ds_run_i low in IDLE then high again; IDLE entry is only via ds_run_i=0.
- ram_we_o and rom_en_o are never high in the same cycle.
- rom_addr_o and ram_addr_o hold their last value when their enable is low.

Decomposition:
- Shared package (ds_pkg) holds:
  - state encoding IDLE/FETCH/WAIT/WRITE/DONE
  - derived constants DST_W=SRC_W/2, DST_H=SRC_H/2, ROM_AW, RAM_AW, ACC_W=PIX_W+2
- One natural sub-module: ds_addr_gen. It holds ox/oy/k counters, computes ROM and RAM addresses, and flags last block.
- FSM, valid shift register and accumulator stay in ds_engine.

Test Plan:
- Uniform ramp: SRC 4x4, ROM_LAT=1, rom[i]=i -> 4 writes.
  - addr0=(0+1+4+5+2)>>2=3, addr1=5, addr2=11, addr3=13.
  - ds_done_o rises 24 cycles after FETCH entry.
- Rounding/saturation: block {1,2,3,4} -> 3; {255,255,255,255} -> 255; {0,0,0,1} -> 0; {0,0,1,1} -> 1.
- Latency sweep: ROM_LAT=1..4 on the 4x4 ramp -> identical RAM contents. Cycles per pixel are 6,7,8,9.
- Handshake: ds_run_i held high -> ds_done_o stays 1 with no second frame. Drop ds_run_i -> ds_done_o=0 next cycle. Re-raise -> second identical frame.
- Early run drop: ds_run_i pulsed for 1 cycle -> full frame written, ds_done_o high exactly 1 cycle, then IDLE.
- Reset mid-frame: assert rst_n=0 during the 2nd WRITE -> all outputs 0 asynchronously with no further RAM writes. A new run restarts at RAM addr 0.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants and state encoding for the 2x2 box-filter down-sampler.
package ds_pkg;
  localparam int DEF_PIX_W   = 8;
  localparam int DEF_SRC_W   = 64;
  localparam int DEF_SRC_H   = 64;
  localparam int DEF_ROM_LAT = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Address/counter widths never collapse to zero bits, even for a 2x2 source.
  function automatic int clog2_1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DST_W  = DEF_SRC_W / 2;
  localparam int DST_H  = DEF_SRC_H / 2;
  localparam int ROM_AW = clog2_1(DEF_SRC_W * DEF_SRC_H);
  localparam int RAM_AW = clog2_1(DEF_SRC_W * DEF_SRC_H / 4);
  localparam int ACC_W  = DEF_PIX_W + 2;
endpackage

// File: rtl/ds_if.sv
// Controller handshake plus ROM read and frame-RAM write buses of the down-sampler.
interface ds_if import ds_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H
);
  localparam int AW_ROM = clog2_1(SRC_W * SRC_H);
  localparam int AW_RAM = clog2_1(SRC_W * SRC_H / 4);

  logic              ds_run_i;
  logic              ds_done_o;
  logic              busy_o;
  logic              rom_en_o;
  logic [AW_ROM-1:0] rom_addr_o;
  logic [PIX_W-1:0]  rom_data_i;
  logic              ram_we_o;
  logic [AW_RAM-1:0] ram_addr_o;
  logic [PIX_W-1:0]  ram_wdata_o;

  modport master (
    input  ds_run_i, rom_data_i,
    output ds_done_o, busy_o, rom_en_o, rom_addr_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
  modport slave (
    output ds_run_i, rom_data_i,
    input  ds_done_o, busy_o, rom_en_o, rom_addr_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/ds_addr_gen.sv
// Block/tap counters (ox, oy, k) and the ROM/RAM addresses derived from them.
module ds_addr_gen import ds_pkg::*; #(
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H,
  localparam int AW_ROM = clog2_1(SRC_W * SRC_H),
  localparam int AW_RAM = clog2_1(SRC_W * SRC_H / 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_fetch,
  input  logic              i_write,
  output logic [AW_ROM-1:0] o_rom_addr,
  output logic [AW_RAM-1:0] o_ram_addr,
  output logic              o_k_last,
  output logic              o_last_blk
);
  localparam int DW = SRC_W / 2;
  localparam int DH = SRC_H / 2;
  localparam int XW = clog2_1(DW);
  localparam int YW = clog2_1(DH);

  logic [XW-1:0]     r_ox;
  logic [YW-1:0]     r_oy;
  logic [1:0]        r_k;
  logic [AW_ROM-1:0] r_rom_hold, w_rom_addr;
  logic [AW_RAM-1:0] r_ram_hold, w_ram_addr;
  logic              w_x_last;

  assign w_x_last   = (r_ox == XW'(DW - 1));
  assign o_last_blk = w_x_last && (r_oy == YW'(DH - 1));
  assign o_k_last   = (r_k == 2'd3);

  // k[0] selects the column tap, k[1] the row tap of the 2x2 block.
  assign w_rom_addr = AW_ROM'({r_oy, r_k[1]}) * AW_ROM'(SRC_W) + AW_ROM'({r_ox, r_k[0]});
  assign w_ram_addr = AW_RAM'(r_oy) * AW_RAM'(DW) + AW_RAM'(r_ox);

  // Addresses are live while their enable is high and frozen otherwise.
  assign o_rom_addr = i_fetch ? w_rom_addr : r_rom_hold;
  assign o_ram_addr = i_write ? w_ram_addr : r_ram_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ox       <= '0;
      r_oy       <= '0;
      r_k        <= '0;
      r_rom_hold <= '0;
      r_ram_hold <= '0;
    end else if (i_clr) begin
      r_ox <= '0;
      r_oy <= '0;
      r_k  <= '0;
    end else begin
      if (i_fetch) begin
        r_k        <= r_k + 2'd1;
        r_rom_hold <= w_rom_addr;
      end
      if (i_write) begin
        r_ram_hold <= w_ram_addr;
        if (w_x_last) begin
          r_ox <= '0;
          r_oy <= o_last_blk ? '0 : r_oy + YW'(1);
        end else begin
          r_ox <= r_ox + XW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/ds_engine.sv
// 2x2 rounding box-filter down-sampler: ROM fetch FSM, latency-matched accumulate, RAM write.
module ds_engine import ds_pkg::*; #(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int SRC_W   = DEF_SRC_W,
  parameter int SRC_H   = DEF_SRC_H,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input logic clk,
  input logic rst_n,
  ds_if.master bus
);
  localparam int AW     = PIX_W + 2;
  localparam int AW_ROM = clog2_1(SRC_W * SRC_H);
  localparam int AW_RAM = clog2_1(SRC_W * SRC_H / 4);

  logic [2:0]         r_state, w_next;
  logic [ROM_LAT:1]   r_vld_pipe;
  logic [1:0]         r_wcnt;
  logic [AW-1:0]      r_acc;
  logic [PIX_W-1:0]   r_wdata_hold, w_avg;
  logic               w_fetch, w_wait, w_write, w_k_last, w_last_blk;
  logic [AW_ROM-1:0]  w_rom_addr;
  logic [AW_RAM-1:0]  w_ram_addr;

  assign w_fetch = (r_state == S_FETCH);
  assign w_wait  = (r_state == S_WAIT);
  assign w_write = (r_state == S_WRITE);

  ds_addr_gen #(.SRC_W(SRC_W), .SRC_H(SRC_H)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == S_IDLE),
    .i_fetch   (w_fetch),
    .i_write   (w_write),
    .o_rom_addr(w_rom_addr),
    .o_ram_addr(w_ram_addr),
    .o_k_last  (w_k_last),
    .o_last_blk(w_last_blk)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.ds_run_i) w_next = S_FETCH;
      S_FETCH: if (w_k_last) w_next = S_WAIT;
      // WAIT spans exactly ROM_LAT cycles; the 4th datum lands in its last one.
      S_WAIT:  if (r_wcnt == 2'(ROM_LAT - 1)) w_next = S_WRITE;
      S_WRITE: w_next = w_last_blk ? S_DONE : S_FETCH;
      S_DONE:  if (!bus.ds_run_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Round half up; the 4-pixel sum plus 2 still fits AW bits.
  assign w_avg = PIX_W'((r_acc + AW'(2)) >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vld_pipe   <= '0;
      r_wcnt       <= '0;
      r_acc        <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state       <= w_next;
      r_vld_pipe[1] <= w_fetch;
      for (int j = 2; j <= ROM_LAT; j++) r_vld_pipe[j] <= r_vld_pipe[j-1];
      r_wcnt <= w_wait ? r_wcnt + 2'd1 : 2'd0;
      if (r_vld_pipe[ROM_LAT])
        r_acc <= r_acc + AW'(bus.rom_data_i);
      else if (w_write || r_state == S_IDLE)
        r_acc <= '0;
      if (w_write) r_wdata_hold <= w_avg;
    end
  end

  assign bus.busy_o      = w_fetch || w_wait || w_write;
  assign bus.ds_done_o   = (r_state == S_DONE);
  assign bus.rom_en_o    = w_fetch;
  assign bus.rom_addr_o  = w_rom_addr;
  assign bus.ram_we_o    = w_write;
  assign bus.ram_addr_o  = w_ram_addr;
  assign bus.ram_wdata_o = w_write ? w_avg : r_wdata_hold;
endmodule

// File: tb/tb_ds_engine.sv
// Four 4x4 down-samplers (ROM_LAT 1..4) sharing one run/reset, checked by a queue scoreboard.
module tb_ds_engine;
  import ds_pkg::*;
  localparam int NI = 4, SW = 4, SH = 4, NPX = (SW/2)*(SH/2), NSRC = SW*SH;
  localparam logic [7:0] RND_IMG [NSRC] = '{1,2,255,255, 3,4,255,255, 0,0,0,0, 0,1,1,1};

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  img [NSRC];
  int unsigned exp_q [NI][$];
  logic        done_a [NI], busy_a [NI], en_a [NI], we_a [NI];
  logic [3:0]  raddr_a [NI];
  logic [1:0]  waddr_a [NI];
  logic [7:0]  wdata_a [NI];
  int          checks = 0, errors = 0;
  int          frames [NI];
  int          nframes = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ds_if #(.PIX_W(8), .SRC_W(SW), .SRC_H(SH)) bus ();
    logic [3:0] apipe [g+1];
    assign bus.ds_run_i = run;
    ds_engine #(.PIX_W(8), .SRC_W(SW), .SRC_H(SH), .ROM_LAT(g+1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
    // ROM returns the addressed pixel g+1 cycles after the address is presented.
    always @(posedge clk) begin
      apipe[0] <= bus.rom_addr_o;
      for (int j = 1; j <= g; j++) apipe[j] <= apipe[j-1];
    end
    assign bus.rom_data_i = img[apipe[g]];
    assign done_a[g]  = bus.ds_done_o;
    assign busy_a[g]  = bus.busy_o;
    assign en_a[g]    = bus.rom_en_o;
    assign we_a[g]    = bus.ram_we_o;
    assign raddr_a[g] = bus.rom_addr_o;
    assign waddr_a[g] = bus.ram_addr_o;
    assign wdata_a[g] = bus.ram_wdata_o;
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Monitor: sole owner of the check counters.
  initial begin : mon
    bit   pdone [NI], pvalid [NI];
    logic [3:0] praddr [NI];
    int   bcnt [NI], nwr [NI];
    bit   prun;
    int unsigned e;
    for (int i = 0; i < NI; i++) begin
      frames[i] = 0; pdone[i] = 0; pvalid[i] = 0; bcnt[i] = 0; nwr[i] = 0; praddr[i] = '0;
    end
    prun = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          chk("reset_outputs", i,
              int'({done_a[i], busy_a[i], en_a[i], we_a[i], raddr_a[i], waddr_a[i], wdata_a[i]}), 0);
          pdone[i] = 0; pvalid[i] = 0; bcnt[i] = 0; nwr[i] = 0;
          continue;
        end
        if (en_a[i] && we_a[i]) chk("rom_en_and_ram_we", i, 1, 0);
        if (we_a[i]) begin
          if (exp_q[i].size() == 0) chk("unexpected_write", i, int'(waddr_a[i]), -1);
          else begin
            e = exp_q[i].pop_front();
            chk("ram_write", i, (int'(waddr_a[i]) << 8) | int'(wdata_a[i]), int'(e));
          end
          nwr[i]++;
        end
        if (!en_a[i] && pvalid[i]) chk("rom_addr_hold", i, int'(raddr_a[i]), int'(praddr[i]));
        if (pdone[i]) chk("done_level", i, int'(done_a[i]), prun ? 1 : 0);
        if (done_a[i] && busy_a[i]) chk("done_with_busy", i, 1, 0);
        if (busy_a[i]) bcnt[i]++;
        if (done_a[i] && !pdone[i]) begin
          chk("frame_cycles", i, bcnt[i], NPX * (5 + i + 1));
          chk("frame_writes", i, nwr[i], NPX);
          frames[i]++;
          bcnt[i] = 0; nwr[i] = 0;
        end
        pdone[i] = done_a[i]; praddr[i] = raddr_a[i]; pvalid[i] = 1;
      end
      if (rst_n) prun = run;
      else prun = 0;
    end
  end

  task automatic push_exp();
    for (int b = 0; b < NPX; b++) begin
      int ox, oy, s;
      ox = b % (SW/2); oy = b / (SW/2); s = 0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) s += int'(img[(2*oy+dy)*SW + 2*ox + dx]);
      for (int i = 0; i < NI; i++) exp_q[i].push_back(unsigned'((b << 8) | ((s + 2) / 4)));
    end
  endtask

  task automatic wait_frames(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk); #2;
      ok = 1;
      for (int i = 0; i < NI; i++) if (frames[i] < target) ok = 0;
    end
    if (!ok) begin
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames[NI-1], target);
      $fatal(1, "timeout");
    end
  endtask

  task automatic run_frame(input int hold, input bit pulse);
    push_exp();
    nframes++;
    @(posedge clk); #1 run = 1'b1;
    if (pulse) begin @(posedge clk); #1 run = 1'b0; end
    wait_frames(nframes);
    repeat (hold) @(posedge clk);
    #1 run = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin : stim
    int nwe;
    for (int i = 0; i < NSRC; i++) img[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(10, 0);          // ramp, run held long after done
    run_frame(2, 0);           // same frame again after re-raise
    img = RND_IMG;
    run_frame(0, 1);           // rounding corner blocks, 1-cycle run pulse
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NSRC; i++) img[i] = 8'($urandom_range(0, 255));
      if (f == 1) for (int i = 0; i < NSRC; i++) img[i] = 8'hFF;
      run_frame(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end
    // Reset during the second WRITE of the ROM_LAT=1 engine.
    for (int i = 0; i < NSRC; i++) img[i] = 8'($urandom_range(0, 255));
    push_exp();
    @(posedge clk); #1 run = 1'b1;
    nwe = 0;
    for (int c = 0; c < 100 && nwe < 2; c++) begin
      @(negedge clk);
      if (we_a[0]) nwe++;
    end
    if (nwe < 2) begin
      $display("FAIL reset_trigger: got %0d writes expected 2", nwe);
      $fatal(1, "timeout");
    end
    #1 rst_n = 1'b0;
    for (int i = 0; i < NI; i++) exp_q[i].delete();
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < NSRC; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame(1, 0);
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
